// File: rtl/scdp_trace_ctrl_if.sv
// Run-control / trace bus for scdp_trace_ctrl: run controls and core observation in,
// core gating, status and trace read-back out.
interface scdp_trace_ctrl_if #(
    parameter int PC_W    = 8,
    parameter int PROBE_W = 4,
    parameter int NPROBE  = 3,
    parameter int DEPTH   = 16,
    parameter int CYC_W   = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = PC_W + NPROBE * PROBE_W;

    logic                     start;
    logic                     stop;
    logic                     clear;
    logic [CYC_W-1:0]         max_cycles;
    logic                     bp_en;
    logic [PC_W-1:0]          bp_pc;
    logic [PC_W-1:0]          pc_in;
    logic [NPROBE*PROBE_W-1:0] probe_in;
    logic [AW-1:0]            rd_addr;

    logic                     core_rst;
    logic                     core_en;
    logic                     halted;
    logic [1:0]               halt_cause;
    logic [CYC_W-1:0]         cycle_count;
    logic [AW:0]              entries;
    logic [DW-1:0]            rd_data;

    modport master (
        output start, stop, clear, max_cycles, bp_en, bp_pc, pc_in, probe_in, rd_addr,
        input  core_rst, core_en, halted, halt_cause, cycle_count, entries, rd_data
    );

    modport slave (
        input  start, stop, clear, max_cycles, bp_en, bp_pc, pc_in, probe_in, rd_addr,
        output core_rst, core_en, halted, halt_cause, cycle_count, entries, rd_data
    );
endinterface

// File: rtl/scdp_trace_ctrl.sv
// Run-control and circular trace capture for the SCDP debug bench: holds the core in reset
// until started, runs it for a bounded number of cycles and records every executed cycle.
module scdp_trace_ctrl #(
    parameter int PC_W    = 8,
    parameter int PROBE_W = 4,
    parameter int NPROBE  = 3,
    parameter int DEPTH   = 16,
    parameter int CYC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    scdp_trace_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = PC_W + NPROBE * PROBE_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_LIMIT = 2'd1,
        CAUSE_BP    = 2'd2,
        CAUSE_STOP  = 2'd3
    } cause_e;

    state_e           state;
    state_e           next_state;

    logic [AW-1:0]    wr_ptr;
    logic             wrapped;
    logic [CYC_W-1:0] cycle_count;
    cause_e           halt_cause;

    logic             core_rst_d;
    logic             core_en_d;
    logic             halted_d;
    logic             core_rst_q;
    logic             core_en_q;
    logic             halted_q;

    logic [DW-1:0]    trace_mem [DEPTH];
    logic [DW-1:0]    rd_data_q;

    // Halt detection on the sample being captured this cycle.
    logic [CYC_W:0]   count_inc;
    logic [CYC_W-1:0] count_next;
    logic             hit_bp;
    logic             hit_limit;
    logic             hit_stop;
    logic             hit_any;
    cause_e           cause_d;

    assign count_inc  = {1'b0, cycle_count} + (CYC_W+1)'(1);
    assign count_next = count_inc[CYC_W] ? cycle_count : count_inc[CYC_W-1:0];
    assign hit_bp     = bus.bp_en && (bus.pc_in == bus.bp_pc);
    assign hit_limit  = (bus.max_cycles != '0) && (count_inc == {1'b0, bus.max_cycles});
    assign hit_stop   = bus.stop;

    // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
    always_comb begin
        cause_d = CAUSE_NONE;
        if (hit_bp) begin
            cause_d = CAUSE_BP;
        end else if (hit_limit) begin
            cause_d = CAUSE_LIMIT;
        end else if (hit_stop) begin
            cause_d = CAUSE_STOP;
        end
    end

    assign hit_any = (cause_d != CAUSE_NONE);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (bus.start) next_state = S_RUN;
            S_RUN:  if (hit_any)   next_state = S_HALT;
            S_HALT: if (bus.clear) next_state = S_IDLE;
            default:               next_state = S_IDLE;
        endcase
    end

    // Core gating is decoded from the next state and registered so it changes with the state.
    always_comb begin
        core_rst_d = 1'b1;
        core_en_d  = 1'b0;
        halted_d   = 1'b0;
        unique case (next_state)
            S_RUN: begin
                core_rst_d = 1'b0;
                core_en_d  = 1'b1;
            end
            S_HALT: begin
                core_rst_d = 1'b0;
                halted_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
            halted_q   <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            wrapped     <= 1'b0;
            cycle_count <= '0;
            halt_cause  <= CAUSE_NONE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        wr_ptr      <= '0;
                        wrapped     <= 1'b0;
                        cycle_count <= '0;
                        halt_cause  <= CAUSE_NONE;
                    end
                end
                S_RUN: begin
                    wr_ptr      <= wr_ptr + AW'(1);
                    cycle_count <= count_next;
                    if (wr_ptr == AW'(DEPTH - 1)) wrapped <= 1'b1;
                    if (hit_any) halt_cause <= cause_d;
                end
                S_HALT: begin
                    if (bus.clear) begin
                        wr_ptr      <= '0;
                        wrapped     <= 1'b0;
                        cycle_count <= '0;
                        halt_cause  <= CAUSE_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the trace RAM is deliberately not reset; wr_ptr/wrapped alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RUN) begin
            trace_mem[wr_ptr] <= {bus.pc_in, bus.probe_in};
        end
    end

    // Logical read index 0 is the oldest surviving sample.
    logic [AW:0]   entries;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_phys;
    logic          rd_in_range;

    assign entries     = wrapped ? (AW+1)'(DEPTH) : {1'b0, wr_ptr};
    assign oldest      = wrapped ? wr_ptr : '0;
    assign rd_phys     = oldest + bus.rd_addr;
    assign rd_in_range = ({1'b0, bus.rd_addr} < entries);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_in_range ? trace_mem[rd_phys] : '0;
        end
    end

    assign bus.core_rst    = core_rst_q;
    assign bus.core_en     = core_en_q;
    assign bus.halted      = halted_q;
    assign bus.halt_cause  = halt_cause;
    assign bus.cycle_count = cycle_count;
    assign bus.entries     = entries;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_scdp_trace_ctrl.sv
// Scoreboard bench for scdp_trace_ctrl: a queue-based trace model predicts status and
// read-back, a monitor compares one cycle after each request.
module tb_scdp_trace_ctrl;
    localparam int PC_W    = 8;
    localparam int PROBE_W = 4;
    localparam int NPROBE  = 3;
    localparam int DEPTH   = 16;
    localparam int CYC_W   = 16;
    localparam int AW      = $clog2(DEPTH);
    localparam int DW      = PC_W + NPROBE * PROBE_W;
    localparam int BUDGET  = 100;

    typedef enum int {K_RD, K_HALTED, K_CAUSE, K_COUNT, K_ENTRIES, K_CORE_RST, K_CORE_EN} kind_e;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scdp_trace_ctrl_if #(.PC_W(PC_W), .PROBE_W(PROBE_W), .NPROBE(NPROBE),
                         .DEPTH(DEPTH), .CYC_W(CYC_W)) bus ();

    scdp_trace_ctrl #(.PC_W(PC_W), .PROBE_W(PROBE_W), .NPROBE(NPROBE),
                      .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    kind_e       exp_kind_q [$];
    logic [63:0] exp_val_q  [$];
    bit          req   = 1'b0;
    bit          req_d = 1'b0;

    // Reference model: the surviving trace, captures since start, latched cause.
    logic [DW-1:0] trace_q [$];
    int            m_count;
    int            m_cause;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic string kind_name(input kind_e k);
        case (k)
            K_RD:       return "rd_data";
            K_HALTED:   return "halted";
            K_CAUSE:    return "halt_cause";
            K_COUNT:    return "cycle_count";
            K_ENTRIES:  return "entries";
            K_CORE_RST: return "core_rst";
            default:    return "core_en";
        endcase
    endfunction

    always @(posedge clk) req_d <= req;

    // Monitor: a request issued in cycle k is answered after the following edge.
    always @(negedge clk) begin
        if (req_d) begin
            if (exp_kind_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got no expectation, required one");
            end else begin
                kind_e       k;
                logic [63:0] e;
                logic [63:0] a;
                k = exp_kind_q.pop_front();
                e = exp_val_q.pop_front();
                case (k)
                    K_RD:       a = 64'(bus.rd_data);
                    K_HALTED:   a = 64'(bus.halted);
                    K_CAUSE:    a = 64'(bus.halt_cause);
                    K_COUNT:    a = 64'(bus.cycle_count);
                    K_ENTRIES:  a = 64'(bus.entries);
                    K_CORE_RST: a = 64'(bus.core_rst);
                    default:    a = 64'(bus.core_en);
                endcase
                check(kind_name(k), a, e);
            end
        end
    end

    task automatic expect_item(input kind_e k, input logic [63:0] v, input int addr);
        bus.rd_addr = AW'(addr);
        exp_kind_q.push_back(k);
        exp_val_q.push_back(v);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic expect_trace();
        for (int a = 0; a < DEPTH; a++) begin
            expect_item(K_RD, (a < trace_q.size()) ? 64'(trace_q[a]) : 64'd0, a);
        end
    endtask

    task automatic expect_halted();
        expect_item(K_HALTED, 64'd1, 0);
        expect_item(K_CAUSE, 64'(m_cause), 0);
        expect_item(K_COUNT, 64'(m_count), 0);
        expect_item(K_ENTRIES, 64'(trace_q.size()), 0);
        expect_item(K_CORE_EN, 64'd0, 0);
        expect_item(K_CORE_RST, 64'd0, 0);
    endtask

    task automatic expect_idle();
        expect_item(K_CORE_RST, 64'd1, 0);
        expect_item(K_CORE_EN, 64'd0, 0);
        expect_item(K_HALTED, 64'd0, 0);
        expect_item(K_ENTRIES, 64'd0, 0);
        expect_item(K_RD, 64'd0, 3);
    endtask

    // One run from IDLE; the model decides from the rules alone when the halt happens.
    task automatic run(input int max_c, input bit bpen, input logic [PC_W-1:0] bppc,
                       input bit pc_rand, input int stop_at, input bit noise);
        logic [PC_W-1:0]          pc;
        logic [NPROBE*PROBE_W-1:0] pr;
        bit                       stp;
        bit                       bp;
        bit                       lim;
        bus.max_cycles = CYC_W'(max_c);
        bus.bp_en      = bpen;
        bus.bp_pc      = bppc;
        bus.stop       = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        trace_q.delete();
        m_count = 0;
        m_cause = 0;
        for (int c = 0; c < BUDGET && m_cause == 0; c++) begin
            pc  = pc_rand ? PC_W'($urandom_range(0, 31)) : PC_W'(c * 4);
            pr  = (NPROBE*PROBE_W)'($urandom);
            stp = (c == stop_at) || (noise && $urandom_range(0, 31) == 0);
            bus.pc_in    = pc;
            bus.probe_in = pr;
            bus.stop     = stp;
            bus.start    = noise && ($urandom_range(0, 7) == 0);
            bus.clear    = noise && ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            trace_q.push_back({pc, pr});
            if (trace_q.size() > DEPTH) void'(trace_q.pop_front());
            m_count++;
            bp  = bpen && (pc == bppc);
            lim = (max_c != 0) && (m_count == max_c);
            m_cause = bp ? 2 : lim ? 1 : stp ? 3 : 0;
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        expect_halted();
        expect_trace();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        trace_q.delete();
        m_count = 0;
        expect_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int max_c;
        int stop_at;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.clear      = 1'b0;
        bus.max_cycles = '0;
        bus.bp_en      = 1'b0;
        bus.bp_pc      = '0;
        bus.pc_in      = '0;
        bus.probe_in   = '0;
        bus.rd_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_item(K_CAUSE, 64'd0, 0);
        expect_item(K_COUNT, 64'd0, 0);
        expect_idle();
        rst = 1'b0;
        @(posedge clk); #1;

        // Limit of 5 with PC stepping by 4.
        run(5, 1'b0, '0, 1'b0, -1, 1'b0);

        // start and stop have no effect while halted.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        expect_halted();
        do_clear();

        // Breakpoint at 0x0C with no limit.
        run(0, 1'b1, 8'h0C, 1'b0, -1, 1'b0);
        do_clear();

        // Wrap-around: 20 captures into 16 entries.
        run(20, 1'b0, '0, 1'b0, -1, 1'b0);
        do_clear();

        // All three conditions together, then limit and stop together.
        run(6, 1'b1, 8'h14, 1'b0, 5, 1'b0);
        do_clear();
        run(6, 1'b0, '0, 1'b0, 5, 1'b0);
        do_clear();

        // Reset in the middle of a run.
        bus.max_cycles = '0;
        bus.bp_en      = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            bus.pc_in = PC_W'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        trace_q.delete();
        m_count = 0;
        expect_item(K_COUNT, 64'd0, 0);
        expect_idle();

        // Randomized runs with ignored start/clear pulses sprinkled in.
        for (int r = 0; r < 8; r++) begin
            max_c   = $urandom_range(0, 40);
            stop_at = (max_c == 0) ? int'($urandom_range(3, 45)) : -1;
            run(max_c, 1'($urandom_range(0, 1)), PC_W'($urandom_range(0, 31)), 1'b1, stop_at, 1'b1);
            do_clear();
        end

        repeat (3) @(posedge clk);
        if (exp_kind_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_kind_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
